// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code copy and a one-cycle wrap pulse.
// gray_out is encoded from the next binary value, so both outputs always describe the same count.
module gray_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  // Next-state selection: load beats count; wrap only on a counted roll-over.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
      if (up) begin
        bin_d  = bin_q + ONE;
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = ~|bin_q;
      end
    end else begin
      bin_d = bin_q;
    end
    gray_d = bin2gray(bin_d);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= {WIDTH{1'b0}};
      gray_q <= {WIDTH{1'b0}};
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed and random checks of gray_counter (WIDTH=5) against a modular-arithmetic model.
module tb_gray_counter;

  localparam int W   = 5;
  localparam int MOD = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = 5'd0;
  logic [W-1:0] bin_out, gray_out;
  logic         wrap;

  int errors = 0;
  int checks = 0;

  int         m_bin = 0;
  bit         m_wrap = 1'b0;
  bit         m_counted = 1'b0;
  logic [W-1:0] prev_gray = 5'd0;

  gray_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(load_val), .bin_out(bin_out), .gray_out(gray_out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [W-1:0] gray_of(input int v);
    int b;
    b = v % MOD;
    return W'(b ^ (b / 2));
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model with the inputs presented at this edge.
  task automatic model_step();
    int old;
    old = m_bin;
    m_counted = 1'b0;
    if (load) begin
      m_bin  = int'(load_val);
      m_wrap = 1'b0;
    end else if (en) begin
      m_counted = 1'b1;
      if (up) begin
        m_bin  = (old + 1) % MOD;
        m_wrap = (old == MOD - 1);
      end else begin
        m_bin  = (old + MOD - 1) % MOD;
        m_wrap = (old == 0);
      end
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bin"}, int'(bin_out), m_bin);
    chk({tag, ".gray"}, int'(gray_out), int'(gray_of(m_bin)));
    chk({tag, ".wrap"}, int'(wrap), int'(m_wrap));
    chk({tag, ".decode"}, int'(g2b(gray_out)), int'(bin_out));
    if (m_counted) chk({tag, ".hamming"}, $countones(prev_gray ^ gray_out), 1);
    prev_gray = gray_out;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    #12;
    chk("reset.bin", int'(bin_out), 0);
    chk("reset.gray", int'(gray_out), 0);
    chk("reset.wrap", int'(wrap), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: count to 9, then reset asynchronously between edges
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 9; i++) tick("t1.count");
    chk("t1.at9", int'(bin_out), 9);
    #2 rst = 1'b1;
    #1;
    chk("t1.async.bin", int'(bin_out), 0);
    chk("t1.async.gray", int'(gray_out), 0);
    chk("t1.async.wrap", int'(wrap), 0);
    m_bin = 0; m_wrap = 1'b0; prev_gray = 5'd0;
    #2 rst = 1'b0;
    tick("t1.resume");
    chk("t1.resume1", int'(bin_out), 1);

    // 2: full up cycle from reset
    @(negedge clk) rst = 1'b1;
    #1;
    m_bin = 0; m_wrap = 1'b0; prev_gray = 5'd0;
    @(negedge clk) rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick("t2.up");
      if (i == 31) chk("t2.gray31", int'(gray_out), int'(5'b10000));
      if (i == 32) begin
        chk("t2.gray0", int'(gray_out), 0);
        chk("t2.wrapat0", int'(wrap), 1);
      end
    end
    tick("t2.after");
    chk("t2.wrapgone", int'(wrap), 0);

    // 3: loads, including load winning over a would-be wrap
    load = 1'b1; load_val = 5'd13; en = 1'b0;
    tick("t3.load13");
    chk("t3.gray13", int'(gray_out), int'(5'b01011));
    load_val = 5'd31;
    tick("t3.load31");
    en = 1'b1; up = 1'b1; load_val = 5'd31;
    tick("t3.loadwins");
    chk("t3.nowrap", int'(wrap), 0);

    // 4: decrement through zero
    load = 1'b1; load_val = 5'd0; en = 1'b0;
    tick("t4.load0");
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick("t4.dec");
    chk("t4.gray31", int'(gray_out), int'(5'b10000));
    chk("t4.wrap", int'(wrap), 1);
    tick("t4.dec2");
    chk("t4.gray30", int'(gray_out), int'(5'b10001));

    // 5: hold, then direction change
    load = 1'b1; load_val = 5'd20;
    tick("t5.load20");
    load = 1'b0; en = 1'b0;
    for (int i = 0; i < 5; i++) tick("t5.hold");
    chk("t5.gray20", int'(gray_out), int'(5'b11110));
    en = 1'b1; up = 1'b1;
    tick("t5.up");
    chk("t5.is21", int'(bin_out), 21);
    up = 1'b0;
    tick("t5.down");
    chk("t5.is20", int'(bin_out), 20);

    // 6: random traffic
    for (int i = 0; i < 500; i++) begin
      load     = ($urandom_range(7) == 0);
      en       = ($urandom_range(3) != 0);
      up       = $urandom_range(1);
      load_val = W'($urandom_range(MOD - 1));
      tick("t6.rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
